ula_sequenciador: RTL and testbench

- Command-side initiator for the 4-bit combinational ALU (AND/OR/ADD/NOT/ANDN/ORN/SUB/LT, 3-bit selector).
- Buffers operation commands in a small FIFO, drives the ALU operand and selector inputs, and samples its result and carry.
- Builds a multi-cycle 4x4->8 multiply out of repeated ALU additions.
- Returns each result through a valid/ready output handshake to the datapath controller.

---
 rtl/ula_sequenciador.sv | 197 +++++++++++++++++++
 tb/tb_ula_sequenciador.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador.sv
// ula_sequenciador: command-side sequencer for a 4-bit combinational ALU.
// Commands are queued in a CMD_DEPTH FIFO. Each one runs as a native ALU op,
// as a 4x4->8 shift-and-add multiply, or is flagged as illegal. Its result is
// returned through a valid/ready handshake.
// Optional feature: define ULA_SEQ_COUNT_EN to enable the res_count counter of
// completed results. When it is undefined, res_count is tied to zero.
module ula_sequenciador #(
  parameter int CMD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_res,
  input  logic       alu_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       res_err,
  output logic [7:0] res_count
);

  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t     r_state, w_next;
  cmd_t       r_fifo [CMD_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic       w_full, w_empty, w_push, w_pop;
  cmd_t       w_head, w_cmd;

  logic [3:0] r_a, r_phi, r_plo;
  logic [1:0] r_i;
  logic [3:0] r_alu_a, r_alu_b;
  logic [2:0] r_alu_sel;
  logic [7:0] r_res_data;
  logic       r_res_carry, r_res_err, r_res_valid;

  logic [4:0] w_sum;
  logic [3:0] w_phi_nx, w_plo_nx;

  // The extra pointer bit tells full from empty when the low bits match.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_fifo[r_rd_ptr[AW-1:0]];
  assign w_cmd   = '{op: cmd_op, a: cmd_a, b: cmd_b};

  assign cmd_ready = !w_full;

  // One multiply step: add into the high half, then shift the 9-bit
  // {carry, sum, P_lo} right by one place.
  assign w_sum    = {alu_cout, alu_res};
  assign w_phi_nx = w_sum[4:1];
  assign w_plo_nx = {w_sum[0], r_plo[3:1]};

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_err   = r_res_err;

  // FIFO storage. It needs no reset because the pointers qualify every read.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= w_cmd;
  end

  // FIFO pointers. Reset discards all queued commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state. Illegal ops go straight to DONE from IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_pop) begin
        if (!w_head.op[3])          w_next = S_EXEC;
        else if (w_head.op == 4'b1000) w_next = S_MUL;
        else                        w_next = S_DONE;
      end
      S_EXEC: w_next = S_DONE;
      S_MUL:  if (r_i == 2'd3) w_next = S_DONE;
      S_DONE: if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. Handles operand latch, ALU drive registers, multiply
  // accumulation and the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_phi       <= '0;
      r_plo       <= '0;
      r_i         <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_a <= w_head.a;
          if (!w_head.op[3]) begin
            r_alu_a   <= w_head.a;
            r_alu_b   <= w_head.b;
            r_alu_sel <= w_head.op[2:0];
          end else if (w_head.op == 4'b1000) begin
            r_phi     <= '0;
            r_plo     <= w_head.b;
            r_i       <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= w_head.b[0] ? w_head.a : 4'd0;
            r_alu_sel <= 3'b010;
          end else begin
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          r_res_data  <= {4'b0, alu_res};
          r_res_carry <= alu_cout;
          r_res_err   <= 1'b0;
          r_res_valid <= 1'b1;
        end
        S_MUL: begin
          r_phi <= w_phi_nx;
          r_plo <= w_plo_nx;
          r_i   <= r_i + 2'd1;
          if (r_i == 2'd3) begin
            r_res_data  <= {w_phi_nx, w_plo_nx};
            r_res_carry <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
          end else begin
            // After the last step the ALU inputs keep their final values.
            r_alu_a <= w_phi_nx;
            r_alu_b <= w_plo_nx[0] ? r_a : 4'd0;
          end
        end
        S_DONE: if (res_ready) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ULA_SEQ_COUNT_EN
  logic [7:0] r_count;

  // Count completed result handshakes, wrapping modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_count <= '0;
    else if (r_res_valid && res_ready)  r_count <= r_count + 8'd1;
  end

  assign res_count = r_count;
`else
  assign res_count = 8'h00;
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// Self-checking bench for ula_sequenciador. It includes a behavioural ALU and
// an arithmetic reference model that keeps a queue of expected results.
module tb_ula_sequenciador;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op, cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_sel;
  logic       alu_cout;
  logic       res_valid, res_ready, res_carry, res_err;
  logic [7:0] res_data, res_count;

  always #5 clk = ~clk;

  ula_sequenciador #(.CMD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_err(res_err),
    .res_count(res_count)
  );

  // ALU behaviour, returned as {carry, result}.
  function automatic logic [4:0] alu_f(input logic [3:0] a, b, input logic [2:0] s);
    case (s)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, a} + {1'b0, b};
      3'd3: return {1'b0, ~a};
      3'd4: return {1'b0, a & ~b};
      3'd5: return {1'b0, a | ~b};
      3'd6: return {1'b0, a} + {1'b0, ~b} + 5'd1;
      default: return {4'b0, (a < b)};
    endcase
  endfunction

  assign {alu_cout, alu_res} = alu_f(alu_a, alu_b, alu_sel);

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       e;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, a, b);
    exp_t x;
    logic [4:0] r;
    if (!op[3]) begin
      r = alu_f(a, b, op[2:0]);
      x = '{d: {4'b0, r[3:0]}, c: r[4], e: 1'b0};
    end else if (op == 4'b1000) begin
      x = '{d: 8'(a * b), c: 1'b0, e: 1'b0};
    end else begin
      x = '{d: 8'h00, c: 1'b0, e: 1'b1};
    end
    return x;
  endfunction

  int   n_chk = 0, n_fail = 0;
  int   n_res = 0, n_cnt = 0;
  exp_t q[$];
  exp_t m_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard. Record accepted commands and compare each handshaked result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) q.push_back(model(cmd_op, cmd_a, cmd_b));
      if (res_valid && res_ready) begin
        if (q.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          m_e = q.pop_front();
          chk("sb_data", res_data, m_e.d);
          chk("sb_carry", res_carry, m_e.c);
          chk("sb_err", res_err, m_e.e);
        end
        n_res++;
        n_cnt++;
      end
    end
  end

  task automatic do_reset();
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; res_ready = 0;
    rst_n = 0;
    q.delete();
    n_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Issue one command from idle and check latency and result values.
  task automatic do_cmd(input logic [3:0] op, a, b, input int exp_lat,
                        input logic [7:0] ed, input logic ec, ee);
    int lat;
    @(posedge clk); #1;
    res_ready = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (res_valid) begin lat = k; break; end
    end
    chk("latency", lat, exp_lat);
    chk("res_data", res_data, ed);
    chk("res_carry", res_carry, ec);
    chk("res_err", res_err, ee);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    cmd_valid = 0; res_ready = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !res_valid) break;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int acc, n0, r;
    do_reset();
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_carry", res_carry, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("rst_count", res_count, 0);

    // Native ops, multiplies and an illegal op.
    do_cmd(4'b0010, 4'd9, 4'd8, 2, 8'h01, 1, 0);
    do_cmd(4'b0110, 4'd5, 4'd7, 2, 8'h0E, 0, 0);
    do_cmd(4'b0110, 4'd7, 4'd5, 2, 8'h02, 1, 0);
    do_cmd(4'b1000, 4'd15, 4'd15, 5, 8'hE1, 0, 0);
    do_cmd(4'b1000, 4'd0, 4'd9, 5, 8'h00, 0, 0);
    do_cmd(4'b1000, 4'd6, 4'd1, 5, 8'h06, 0, 0);
    do_cmd(4'b1011, 4'd3, 4'd4, 1, 8'h00, 0, 1);
    do_cmd(4'b0000, 4'd12, 4'd10, 2, 8'h08, 0, 0);

    // Backpressure: with res_ready low, only CMD_DEPTH+1 commands are accepted.
    @(posedge clk); #1 res_ready = 0;
    acc = 0;
    for (int k = 1; k <= 7; k++) begin
      cmd_valid = 1; cmd_op = 4'b0010; cmd_a = 4'(k); cmd_b = 4'(k + 1);
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    chk("bp_accepted", acc, 5);
    chk("bp_full_ready", cmd_ready, 0);
    n0 = n_res;
    res_ready = 1;
    r = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin r = 1; break; end
    end
    chk("bp_ready_rise", r, 1);
    chk("bp_results_at_rise", n_res - n0, 1);
    drain();
    chk("bp_results", n_res - n0, 5);

    // Reset in the second MUL cycle with two commands queued.
    @(posedge clk); #1;
    res_ready = 1; cmd_valid = 1; cmd_op = 4'b1000; cmd_a = 4'd15; cmd_b = 4'd15;
    @(posedge clk); #1 cmd_op = 4'b0010; cmd_a = 4'd1; cmd_b = 4'd2;
    @(posedge clk); #1 cmd_op = 4'b0010; cmd_a = 4'd3; cmd_b = 4'd4;
    @(posedge clk); #1 cmd_valid = 0;
    #2 rst_n = 0;
    #1;
    q.delete();
    n_cnt = 0;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    r = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) r++;
    end
    chk("midrst_no_stale", r, 0);
    do_cmd(4'b0001, 4'd5, 4'd10, 2, 8'h0F, 0, 0);

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(0, 9));
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op = (r < 6) ? 4'($urandom_range(0, 7)) :
               (r < 8) ? 4'b1000 : 4'($urandom_range(9, 15));
      cmd_a = 4'($urandom);
      cmd_b = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    // Result counter, starting from a fresh reset.
    do_reset();
    acc = 0;
    for (int k = 0; k < 5000 && acc < 257; k++) begin
      res_ready = 1; cmd_valid = 1;
      cmd_op = 4'($urandom_range(0, 7)); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk); #1;
    end
    drain();
    chk("cnt_results", n_cnt, 257);
`ifdef ULA_SEQ_COUNT_EN
    chk("res_count_wrap", res_count, 1);
`else
    chk("res_count_tied", res_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
